// File: rtl/control_fsm.sv
// Multi-cycle MIPS-subset control unit: FETCH/DECODE plus one execution path per instruction class.
// Define CONTROL_FSM_EXC_EN to trap illegal instructions in EXC; otherwise they execute as no-ops.
module control_fsm (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUCtl,
  output logic [1:0] PCSource,
  output logic       PCEn,
  output logic [3:0] State,
  output logic       Exc
);

  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OP_W-1:0] OP_J     = 6'h02;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE   = 6'h05;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'h08;
  localparam logic [OP_W-1:0] OP_LW    = 6'h23;
  localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

  localparam logic [OP_W-1:0] FN_ADD = 6'h20;
  localparam logic [OP_W-1:0] FN_SUB = 6'h22;
  localparam logic [OP_W-1:0] FN_AND = 6'h24;
  localparam logic [OP_W-1:0] FN_OR  = 6'h25;
  localparam logic [OP_W-1:0] FN_SLT = 6'h2A;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EX     = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDI_EX  = 4'd10,
    S_ADDI_WB  = 4'd11,
    S_EXC      = 4'd12
  } state_e;

`ifdef CONTROL_FSM_EXC_EN
  localparam state_e S_ILLEGAL = S_EXC;
`else
  localparam state_e S_ILLEGAL = S_FETCH;
`endif

  state_e state_q, state_d;
  logic   funct_legal_c;

  assign funct_legal_c = (Funct == FN_ADD) || (Funct == FN_SUB) || (Funct == FN_AND) ||
                         (Funct == FN_OR)  || (Funct == FN_SLT);
  assign State = 4'(state_q);

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next state and control outputs; everything is forced low while Reset is high.
  always_comb begin
    state_d  = S_FETCH;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IorD     = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    ALUCtl   = ALU_AND;
    PCSource = 2'd0;
    PCEn     = 1'b0;
    Exc      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'd1;
        ALUCtl  = ALU_ADD;
        IRWrite = MemReady;
        PCEn    = MemReady;
        state_d = MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'd3;
        ALUCtl  = ALU_ADD;
        case (Opcode)
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_RTYPE:        state_d = funct_legal_c ? S_R_EX : S_ILLEGAL;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ADDI:         state_d = S_ADDI_EX;
          default:         state_d = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUCtl  = ALU_ADD;
        state_d = (Opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MemReady ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = MemReady ? S_FETCH : S_MEM_WR;
      end
      S_R_EX: begin
        ALUSrcA = 1'b1;
        state_d = S_R_WB;
        case (Funct)
          FN_ADD:  ALUCtl = ALU_ADD;
          FN_SUB:  ALUCtl = ALU_SUB;
          FN_OR:   ALUCtl = ALU_OR;
          FN_SLT:  ALUCtl = ALU_SLT;
          default: ALUCtl = ALU_AND;
        endcase
      end
      S_R_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUCtl   = ALU_SUB;
        PCSource = 2'd1;
        PCEn     = (Opcode == OP_BNE) ? ~Zero : Zero;
      end
      S_JUMP: begin
        PCSource = 2'd2;
        PCEn     = 1'b1;
      end
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ALUCtl  = ALU_ADD;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: RegWrite = 1'b1;
`ifdef CONTROL_FSM_EXC_EN
      S_EXC: begin
        Exc      = 1'b1;
        PCSource = 2'd3;
        PCEn     = 1'b1;
      end
`endif
      default: state_d = S_FETCH;
    endcase
    if (Reset) begin
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      RegDst   = 1'b0;
      MemtoReg = 1'b0;
      ALUSrcA  = 1'b0;
      ALUSrcB  = 2'd0;
      ALUCtl   = 3'd0;
      PCSource = 2'd0;
      PCEn     = 1'b0;
      Exc      = 1'b0;
    end
  end

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-cycle expected control words are queued as stimulus is driven.
// Honours CONTROL_FSM_EXC_EN the same way the design does.
module tb_control_fsm;

  typedef struct packed {
    logic [3:0] st;
    logic       mr, mw, iord, irw, rw, rdst, m2r, srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic [1:0] pcs;
    logic       pcen, exc;
  } exp_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [5:0] Opcode = 6'h00;
  logic [5:0] Funct = 6'h00;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b1;
  logic       MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUCtl;
  logic       PCEn, Exc;
  logic [3:0] State;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];
  string cur_tag = "reset";

  control_fsm dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtl(ALUCtl), .PCSource(PCSource),
    .PCEn(PCEn), .State(State), .Exc(Exc)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (st got %0d exp %0d)", tag, got, exp,
               got[20:17], exp[20:17]);
    end
  endtask

  function automatic exp_t e_st(input logic [3:0] st);
    exp_t e = '0;
    e.st = st;
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic rdy);
    exp_t e = e_st(4'd0);
    e.mr = 1'b1; e.srcb = 2'd1; e.alu = 3'b010; e.irw = rdy; e.pcen = rdy;
    return e;
  endfunction

  function automatic exp_t e_alu(input logic [3:0] st, input logic srca, input logic [1:0] srcb,
                                 input logic [2:0] alu);
    exp_t e = e_st(st);
    e.srca = srca; e.srcb = srcb; e.alu = alu;
    return e;
  endfunction

  function automatic exp_t e_mem(input logic [3:0] st, input logic wr);
    exp_t e = e_st(st);
    e.iord = 1'b1; e.mr = ~wr; e.mw = wr;
    return e;
  endfunction

  function automatic exp_t e_wb(input logic [3:0] st, input logic rdst, input logic m2r);
    exp_t e = e_st(st);
    e.rw = 1'b1; e.rdst = rdst; e.m2r = m2r;
    return e;
  endfunction

  function automatic exp_t e_pc(input logic [3:0] st, input logic [1:0] pcs, input logic pcen);
    exp_t e = e_st(st);
    e.pcs = pcs; e.pcen = pcen;
    return e;
  endfunction

  // Push the expected word, then compare it against the DUT on the falling edge.
  task automatic cyc(input exp_t e);
    exp_t want;
    exp_t got;
    sb_q.push_back(e);
    @(negedge Clk);
    got = '{st: State, mr: MemRead, mw: MemWrite, iord: IorD, irw: IRWrite, rw: RegWrite,
            rdst: RegDst, m2r: MemtoReg, srca: ALUSrcA, srcb: ALUSrcB, alu: ALUCtl,
            pcs: PCSource, pcen: PCEn, exc: Exc};
    want = sb_q.pop_front();
    check(cur_tag, got, want);
    @(posedge Clk);
    #1;
  endtask

  task automatic illegal_tail();
`ifdef CONTROL_FSM_EXC_EN
    exp_t e = e_pc(4'd12, 2'd3, 1'b1);
    e.exc = 1'b1;
    cyc(e);
`endif
  endtask

  task automatic fetch_decode(input int fst);
    for (int i = 0; i < fst; i++) begin
      MemReady = 1'b0;
      cyc(e_fetch(1'b0));
    end
    MemReady = 1'b1;
    cyc(e_fetch(1'b1));
    cyc(e_alu(4'd1, 1'b0, 2'd3, 3'b010));
  endtask

  task automatic run(input string tag, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input int fst, input int mst);
    cur_tag = tag;
    Opcode = op; Funct = fn; Zero = z;
    fetch_decode(fst);
    case (op)
      6'h23: begin
        cyc(e_alu(4'd2, 1'b1, 2'd2, 3'b010));
        for (int i = 0; i < mst; i++) begin
          MemReady = 1'b0;
          cyc(e_mem(4'd3, 1'b0));
        end
        MemReady = 1'b1;
        cyc(e_mem(4'd3, 1'b0));
        cyc(e_wb(4'd4, 1'b0, 1'b1));
      end
      6'h2B: begin
        cyc(e_alu(4'd2, 1'b1, 2'd2, 3'b010));
        for (int i = 0; i < mst; i++) begin
          MemReady = 1'b0;
          cyc(e_mem(4'd5, 1'b1));
        end
        MemReady = 1'b1;
        cyc(e_mem(4'd5, 1'b1));
      end
      6'h00: begin
        case (fn)
          6'h20: cyc(e_alu(4'd6, 1'b1, 2'd0, 3'b010));
          6'h22: cyc(e_alu(4'd6, 1'b1, 2'd0, 3'b110));
          6'h24: cyc(e_alu(4'd6, 1'b1, 2'd0, 3'b000));
          6'h25: cyc(e_alu(4'd6, 1'b1, 2'd0, 3'b001));
          6'h2A: cyc(e_alu(4'd6, 1'b1, 2'd0, 3'b111));
          default: illegal_tail();
        endcase
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) cyc(e_wb(4'd7, 1'b1, 1'b0));
      end
      6'h04, 6'h05: begin
        exp_t e = e_pc(4'd8, 2'd1, (op == 6'h04) ? z : ~z);
        e.srca = 1'b1; e.alu = 3'b110;
        cyc(e);
      end
      6'h02: cyc(e_pc(4'd9, 2'd2, 1'b1));
      6'h08: begin
        cyc(e_alu(4'd10, 1'b1, 2'd2, 3'b010));
        cyc(e_wb(4'd11, 1'b0, 1'b0));
      end
      default: illegal_tail();
    endcase
    MemReady = 1'b1;
  endtask

  logic [5:0] ops[12] = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h04,
                          6'h05, 6'h02, 6'h08, 6'h3F};
  logic [5:0] fns[7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h21, 6'h00};

  initial begin
    // Two reset cycles with MemReady high: FETCH code but every control low.
    @(posedge Clk); #1;
    cyc(e_st(4'd0));
    cyc(e_st(4'd0));
    Reset = 1'b0;

    run("lw_stall3", 6'h23, 6'h00, 1'b0, 0, 3);
    run("sw", 6'h2B, 6'h00, 1'b0, 0, 0);
    run("slt", 6'h00, 6'h2A, 1'b0, 0, 0);
    run("beq_z1", 6'h04, 6'h00, 1'b1, 0, 0);
    run("bne_z1", 6'h05, 6'h00, 1'b1, 0, 0);
    run("bne_z0", 6'h05, 6'h00, 1'b0, 0, 0);
    run("jump", 6'h02, 6'h00, 1'b0, 0, 0);
    run("addi_fstall", 6'h08, 6'h00, 1'b0, 2, 0);
    run("illegal_op", 6'h3F, 6'h00, 1'b0, 0, 0);
    run("illegal_fn", 6'h00, 6'h21, 1'b0, 0, 0);

    cur_tag = "rst_r_ex";
    Opcode = 6'h00; Funct = 6'h20;
    fetch_decode(0);
    Reset = 1'b1;
    cyc(e_st(4'd6));
    Reset = 1'b0;

    cur_tag = "rst_mem_rd";
    Opcode = 6'h23;
    fetch_decode(0);
    cyc(e_alu(4'd2, 1'b1, 2'd2, 3'b010));
    MemReady = 1'b0;
    cyc(e_mem(4'd3, 1'b0));
    Reset = 1'b1;
    cyc(e_st(4'd3));
    Reset = 1'b0;
    MemReady = 1'b1;

    for (int k = 0; k < 40; k++) begin
      int oi = $urandom_range(0, 11);
      int fi = $urandom_range(0, 6);
      run("random", ops[oi], fns[fi], 1'($urandom_range(0, 1)),
          $urandom_range(0, 1), $urandom_range(0, 2));
    end

    cur_tag = "final_fetch";
    cyc(e_fetch(1'b1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
